udp_tx_buffer: RTL and testbench
================================

// Module: udp_tx_buffer
// PURPOSE
//  Downstream stage of the UDP encoder. Captures the encoder's 32-bit word stream
//  (header word 0, header word 1, payload words) into an internal RAM. Waits for fin,
//  then replays the packet on a valid/ready stream with the final checksum inserted
//  into header word 1 bits [15:0]. This lets the encoder's end-of-packet checksum
//  be placed in the header before any word leaves the block.
// PARAMETERS
//  ADDR_WIDTH  9   word-address width; buffer depth DEPTH = 2**ADDR_WIDTH words
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  in_data      in   32  word from encoder (pkg_data)
//  in_wr_en     in   1   in_data valid this cycle (encoder wr_en)
//  in_fin       in   1   packet complete, level (encoder fin; held high until encoder reset)
//  in_checksum  in   16  final checksum, valid while in_fin=1 (encoder checksum_out)
//  out_data     out  32  output word
//  out_valid    out  1   out_data valid
//  out_ready    in   1   sink accepts word when out_valid && out_ready
//  out_last     out  1   marks final word of packet (qualified by out_valid)
//  done         out  1   packet fully sent; held until in_fin falls
//  err_runt     out  1   sticky: fin seen with fewer than 2 words captured
//  err_ovf      out  1   sticky: write dropped (buffer full or not in FILL)
// BEHAVIOUR
//  Reset: state=FILL, wr_ptr=0, rd_ptr=0, all outputs 0 (out_data=0). Reset mid-packet aborts it.
//  States: FILL -> PRIME -> SEND -> DONE -> FILL.
//  FILL: each cycle with in_wr_en=1 writes in_data to mem[wr_ptr], wr_ptr++.
//   - wr_ptr is ADDR_WIDTH+1 bits; when wr_ptr==DEPTH the write is dropped, err_ovf<=1, no wrap.
//   - fin_rise = in_fin && !fin_q (fin_q = in_fin registered, reset to 0).
//   - On fin_rise: chk_q<=in_checksum, count<=wr_ptr (+1 if in_wr_en is also high this cycle;
//     that write completes first).
//   - If the resulting count<2: err_runt<=1, go to DONE, no output.
//   - Otherwise go to PRIME.
//   - If in_fin is already high when FILL is entered, it is not treated as a new packet
//     (edge detect only).
//  PRIME (1 cycle): issue synchronous RAM read of addr 0, rd_ptr<=1; next SEND.
//  SEND: out_valid=1, out_data = RAM word for index rd_ptr-1.
//   - If index==1, out_data = {word[31:16], chk_q}.
//   - out_last=1 when index==count-1.
//   - out_data/out_last are held stable while out_valid && !out_ready.
//   - On handshake, the next word is presented the following cycle (prefetch read),
//     so output is back-to-back with out_ready=1.
//   - Handshake on the last word: out_valid<=0, out_last<=0, go DONE.
//  DONE: done=1. When in_fin==0: done<=0, wr_ptr<=0, rd_ptr<=0, go FILL.
//   - err_* are cleared only by reset.
//  in_wr_en outside FILL: dropped, err_ovf<=1.
//  Latency: first out_valid is 2 cycles after the cycle where fin_rise is sampled.
//  Checksum value is passed unmodified (0x0000 = no checksum, per encoder).
//  Full-depth packet (count==DEPTH) is legal; the DEPTH+1-th write is the first dropped.
// TESTING
//  1. Writes 0x1234_5678, 0x0010_0000, 0xAABB_CCDD, 0x0102_0304, then fin with chk=0xBEEF, ready=1
//     -> 4 consecutive out words 0x12345678, 0x0010BEEF, 0xAABBCCDD, 0x01020304;
//     out_last on 4th; done=1.
//  2. Same packet with out_ready toggling 1,0,0,1... -> identical word sequence, no duplicates/loss;
//     out_data stable during stalls.
//  3. Single write then fin -> err_runt=1, out_valid never asserts, done=1; drop in_fin -> FILL.
//  4. ADDR_WIDTH=2: 5 writes then fin -> err_ovf=1, 4 words out, 5th absent, out_last on word 4.
//  5. Reset asserted mid-SEND after 2 words -> next cycle out_valid=0, done=0, pointers 0;
//     new packet then sent correctly.
//  6. in_wr_en and fin_rise in same cycle (3rd word) -> 3 words out, last word is the coincident one.

Source files
------------

// File: rtl/udp_tx_buffer.sv
// udp_tx_buffer: store-and-forward stage behind the UDP encoder.
// Captures the encoder's word stream into a local RAM. After fin rises, the
// packet is replayed on a valid/ready stream with the final checksum patched
// into header word 1 bits [15:0]. The patch happens before any word leaves.
module udp_tx_buffer #(
   parameter int ADDR_WIDTH = 9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] in_data,
   input  logic        in_wr_en,
   input  logic        in_fin,
   input  logic [15:0] in_checksum,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        done,
   output logic        err_runt,
   output logic        err_ovf
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   // Pointers carry one extra bit so that a completely full buffer (== DEPTH)
   // can be told apart from an empty one.
   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] PTR_FULL = PW'(DEPTH);
   localparam logic [PW-1:0] PTR_ONE  = PW'(1);
   localparam logic [PW-1:0] PTR_TWO  = PW'(2);

   typedef enum logic [1:0] {
      ST_FILL,
      ST_PRIME,
      ST_SEND,
      ST_DONE
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   count_q, count_d;
   logic [15:0]     chk_q, chk_d;
   logic            fin_q, fin_d;
   logic            err_runt_q, err_runt_d;
   logic            err_ovf_q, err_ovf_d;

   logic [31:0]     mem [DEPTH];
   logic [31:0]     rd_data_q;
   logic            ram_wr_en;
   logic            ram_rd_en;
   logic [ADDR_WIDTH-1:0] ram_rd_addr;

   logic            fin_rise;
   logic            wr_fire;
   logic            wr_drop;
   logic            handshake;
   logic            at_last;
   logic [PW-1:0]   fin_count;

   // Shared decode: fin edge, accepted/dropped writes, output handshake.
   always_comb begin
      fin_rise  = in_fin && !fin_q;
      at_last   = (rd_ptr_q == count_q);
      handshake = (state_q == ST_SEND) && out_ready;
      wr_fire   = in_wr_en && (state_q == ST_FILL) && (wr_ptr_q != PTR_FULL);
      wr_drop   = in_wr_en && !wr_fire;
      // A write that coincides with the fin edge completes first and is counted.
      fin_count = wr_ptr_q + PW'(wr_fire);
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (reset) state_q <= ST_FILL;
      else       state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_FILL: begin
            if (fin_rise) begin
               if (fin_count < PTR_TWO) state_d = ST_DONE;
               else                     state_d = ST_PRIME;
            end
         end
         ST_PRIME: state_d = ST_SEND;
         ST_SEND:  if (handshake && at_last) state_d = ST_DONE;
         ST_DONE:  if (!in_fin) state_d = ST_FILL;
         default:  state_d = ST_FILL;
      endcase
   end

   // Outputs and RAM read control decoded from the current state.
   always_comb begin
      out_valid   = (state_q == ST_SEND);
      out_last    = out_valid && at_last;
      done        = (state_q == ST_DONE);
      err_runt    = err_runt_q;
      err_ovf     = err_ovf_q;
      out_data    = '0;
      if (out_valid) begin
         out_data = rd_data_q;
         // rd_ptr runs one ahead of the presented word, so 2 means header word 1.
         if (rd_ptr_q == PTR_TWO) out_data[15:0] = chk_q;
      end
      // Prefetch the next word on each accepted beat to keep output back-to-back.
      ram_rd_en   = (state_q == ST_PRIME) || (handshake && !at_last);
      ram_rd_addr = (state_q == ST_PRIME) ? '0 : rd_ptr_q[ADDR_WIDTH-1:0];
      ram_wr_en   = wr_fire;
   end

   // Datapath next values: pointers, captured count/checksum, sticky errors.
   always_comb begin
      // NOTE: every combinational output is defaulted first so no path leaves it
      // unassigned, which would otherwise infer a latch.
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      chk_d      = chk_q;
      fin_d      = in_fin;
      err_runt_d = err_runt_q;
      err_ovf_d  = err_ovf_q || wr_drop;
      case (state_q)
         ST_FILL: begin
            if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (fin_rise) begin
               chk_d   = in_checksum;
               count_d = fin_count;
               if (fin_count < PTR_TWO) err_runt_d = 1'b1;
            end
         end
         ST_PRIME: rd_ptr_d = PTR_ONE;
         ST_SEND:  if (handshake && !at_last) rd_ptr_d = rd_ptr_q + PTR_ONE;
         ST_DONE: begin
            if (!in_fin) begin
               wr_ptr_d = '0;
               rd_ptr_d = '0;
            end
         end
         default: ;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         chk_q      <= '0;
         fin_q      <= 1'b0;
         err_runt_q <= 1'b0;
         err_ovf_q  <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         chk_q      <= chk_d;
         fin_q      <= fin_d;
         err_runt_q <= err_runt_d;
         err_ovf_q  <= err_ovf_d;
      end
   end

   // Packet RAM with registered read port.
   // NOTE: the array and its read register are deliberately not reset so the
   // tools can map them onto block RAM; out_data is masked while not valid.
   always_ff @(posedge clk) begin
      if (ram_wr_en) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= in_data;
      if (ram_rd_en) rd_data_q <= mem[ram_rd_addr];
   end

endmodule

// File: tb/tb_udp_tx_buffer.sv
// tb_udp_tx_buffer: directed and randomized checks of udp_tx_buffer.
// Two instances share stimulus: a default-depth one and a 4-word one, so the
// overflow and full-depth boundaries are reached with short packets.
`timescale 1ns/1ps
module tb_udp_tx_buffer;

   localparam int DEPTH_A = 512;
   localparam int DEPTH_S = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] in_data;
   logic        in_wr_en;
   logic        in_fin;
   logic [15:0] in_checksum;
   logic        out_ready;

   logic [31:0] a_out_data, s_out_data;
   logic        a_out_valid, s_out_valid;
   logic        a_out_last, s_out_last;
   logic        a_done, s_done;
   logic        a_err_runt, s_err_runt;
   logic        a_err_ovf, s_err_ovf;

   always #5 clk = ~clk;

   udp_tx_buffer #(.ADDR_WIDTH(9)) dut_a (
      .clk(clk), .reset(reset), .in_data(in_data), .in_wr_en(in_wr_en),
      .in_fin(in_fin), .in_checksum(in_checksum), .out_data(a_out_data),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_last(a_out_last),
      .done(a_done), .err_runt(a_err_runt), .err_ovf(a_err_ovf)
   );

   udp_tx_buffer #(.ADDR_WIDTH(2)) dut_s (
      .clk(clk), .reset(reset), .in_data(in_data), .in_wr_en(in_wr_en),
      .in_fin(in_fin), .in_checksum(in_checksum), .out_data(s_out_data),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_last(s_out_last),
      .done(s_done), .err_runt(s_err_runt), .err_ovf(s_err_ovf)
   );

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [31:0] pkt[$];
   logic [15:0] cur_chk;
   logic [32:0] a_q[$];
   logic [32:0] s_q[$];
   bit          exp_runt, exp_ovf_a, exp_ovf_s;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Stream monitors: collect accepted beats and check hold-during-stall.
   logic        a_stall_q = 1'b0;
   logic        s_stall_q = 1'b0;
   logic [33:0] a_prev_q  = '0;
   logic [33:0] s_prev_q  = '0;

   always @(negedge clk) begin
      if (!reset && a_stall_q)
         check("a_hold", {a_out_valid, a_out_last, a_out_data}, a_prev_q);
      a_stall_q <= !reset && a_out_valid && !out_ready;
      a_prev_q  <= {a_out_valid, a_out_last, a_out_data};
      if (!reset && a_out_valid && out_ready) a_q.push_back({a_out_last, a_out_data});
   end

   always @(negedge clk) begin
      if (!reset && s_stall_q)
         check("s_hold", {s_out_valid, s_out_last, s_out_data}, s_prev_q);
      s_stall_q <= !reset && s_out_valid && !out_ready;
      s_prev_q  <= {s_out_valid, s_out_last, s_out_data};
      if (!reset && s_out_valid && out_ready) s_q.push_back({s_out_last, s_out_data});
   end

   task automatic check_idle(input string nm);
      check($sformatf("%s_a_idle", nm),
            {a_out_valid, a_out_last, a_done, a_err_runt, a_err_ovf, a_out_data}, 0);
      check($sformatf("%s_s_idle", nm),
            {s_out_valid, s_out_last, s_done, s_err_runt, s_err_ovf, s_out_data}, 0);
   endtask

   // Reference: the first min(n, depth) words in order, header word 1 carrying
   // the checksum in its low half, last flag on the final one; none if a runt.
   task automatic compare_stream(input string nm, input int cnt, input bit use_s);
      logic [32:0] got[$];
      logic [31:0] w;
      int          exp_n;
      exp_n = (cnt >= 2) ? cnt : 0;
      if (use_s) got = s_q;
      else       got = a_q;
      check($sformatf("%s_nwords", nm), got.size(), exp_n);
      for (int i = 0; i < exp_n && i < got.size(); i++) begin
         w = pkt[i];
         if (i == 1) w[15:0] = cur_chk;
         check($sformatf("%s_word%0d", nm, i), got[i], {(i == exp_n - 1), w});
      end
   endtask

   task automatic load_packet(input logic [15:0] chk, input bit coincide, input bit gaps);
      int  n;
      bit  fin_up;
      n      = pkt.size();
      fin_up = 1'b0;
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 2)) begin
               @(posedge clk); #1 in_wr_en = 1'b0;
            end
         end
         @(posedge clk); #1;
         in_wr_en = 1'b1;
         in_data  = pkt[i];
         if (coincide && i == n - 1) begin
            in_fin      = 1'b1;
            in_checksum = chk;
            fin_up      = 1'b1;
         end
      end
      if (!fin_up) begin
         @(posedge clk); #1;
         in_wr_en    = 1'b0;
         in_fin      = 1'b1;
         in_checksum = chk;
      end
   endtask

   task automatic run_packet(input logic [15:0] chk, input bit coincide, input int rmode,
                             input bit gaps, input bit stray);
      int n, cnt_a, cnt_s;
      n     = pkt.size();
      cnt_a = (n > DEPTH_A) ? DEPTH_A : n;
      cnt_s = (n > DEPTH_S) ? DEPTH_S : n;
      cur_chk = chk;
      a_q.delete();
      s_q.delete();
      load_packet(chk, coincide, gaps);
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (c == 1) begin
            check("lat_prime_a", a_out_valid, 0);
            check("lat_prime_s", s_out_valid, 0);
         end
         if (c == 2) begin
            check("lat_first_a", a_out_valid, cnt_a >= 2);
            check("lat_first_s", s_out_valid, cnt_s >= 2);
         end
         if (c >= 2 && a_done && s_done) break;
         @(posedge clk); #1;
         in_wr_en = 1'b0;
         case (rmode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((c + 1) % 3 == 2);
            default: out_ready = 1'($urandom_range(0, 1));
         endcase
      end
      check("pkt_done", {a_done, s_done}, 2'b11);
      if (cnt_a < 2)     exp_runt  = 1'b1;
      if (n > DEPTH_A)   exp_ovf_a = 1'b1;
      if (n > DEPTH_S)   exp_ovf_s = 1'b1;
      compare_stream("a", cnt_a, 1'b0);
      compare_stream("s", cnt_s, 1'b1);
      if (stray) begin
         @(posedge clk); #1;
         in_wr_en = 1'b1;
         in_data  = $urandom;
         @(posedge clk); #1 in_wr_en = 1'b0;
         exp_ovf_a = 1'b1;
         exp_ovf_s = 1'b1;
         @(negedge clk);
      end
      check("a_errs", {a_err_runt, a_err_ovf}, {exp_runt, exp_ovf_a});
      check("s_errs", {s_err_runt, s_err_ovf}, {exp_runt, exp_ovf_s});
      @(posedge clk); #1;
      in_fin    = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("back_to_fill", {a_done, s_done, a_out_valid, s_out_valid}, 0);
   endtask

   initial begin
      bit got2;
      int n;
      reset       = 1'b1;
      in_data     = '0;
      in_wr_en    = 1'b0;
      in_fin      = 1'b0;
      in_checksum = '0;
      out_ready   = 1'b0;
      exp_runt    = 1'b0;
      exp_ovf_a   = 1'b0;
      exp_ovf_s   = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle("reset");
      @(posedge clk); #1 reset = 1'b0;

      // Basic packet, sink always ready; 4 words is also full depth for dut_s.
      pkt = '{32'h1234_5678, 32'h0010_0000, 32'hAABB_CCDD, 32'h0102_0304};
      run_packet(16'hBEEF, 1'b0, 0, 1'b0, 1'b0);
      // Same packet under a 1,0,0 ready pattern.
      run_packet(16'hBEEF, 1'b0, 1, 1'b0, 1'b0);
      // Runt: single word.
      pkt = '{32'hDEAD_0001};
      run_packet(16'h1111, 1'b0, 0, 1'b0, 1'b0);
      // Five words: overflows the 4-deep instance.
      pkt = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044, 32'h0000_0055};
      run_packet(16'h2222, 1'b0, 0, 1'b0, 1'b0);
      // Write coincident with the fin edge.
      pkt = '{32'hC0DE_0001, 32'hC0DE_0002, 32'hC0DE_0003};
      run_packet(16'h3333, 1'b1, 0, 1'b0, 1'b0);

      // Randomized packets: length, gaps, ready pattern, coincident fin.
      for (int k = 0; k < 40; k++) begin
         pkt.delete();
         n = $urandom_range(0, 9);
         for (int i = 0; i < n; i++) pkt.push_back($urandom);
         run_packet(16'($urandom), (n > 0) && ($urandom_range(0, 1) == 1),
                    $urandom_range(0, 2), 1'b1, 1'b0);
      end

      // Write attempted while not in FILL.
      pkt = '{32'h5555_0000, 32'h6666_0000};
      run_packet(16'h4444, 1'b0, 0, 1'b0, 1'b1);

      // Reset in the middle of sending, then a fresh packet.
      pkt = '{32'hA000_0001, 32'hA000_0002, 32'hA000_0003, 32'hA000_0004};
      a_q.delete();
      s_q.delete();
      load_packet(16'h7777, 1'b0, 1'b0);
      got2 = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge clk); #1;
         if (a_q.size() >= 2) begin
            got2 = 1'b1;
            break;
         end
         @(posedge clk); #1;
         in_wr_en  = 1'b0;
         out_ready = 1'b1;
      end
      check("midsend_two_words", got2, 1);
      @(posedge clk); #1;
      reset    = 1'b1;
      in_fin   = 1'b0;
      in_wr_en = 1'b0;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      check_idle("midsend_reset");
      exp_runt  = 1'b0;
      exp_ovf_a = 1'b0;
      exp_ovf_s = 1'b0;
      out_ready = 1'b0;
      pkt = '{32'hB000_0001, 32'hB000_0002, 32'hB000_0003};
      run_packet(16'h5A5A, 1'b0, 2, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
